// File: rtl/spi_sram_pkg.sv
// rtl/spi_sram_pkg.sv - opcodes, status mode encodings and FSM states for spi_sram_slave
package spi_sram_pkg;

    localparam logic [7:0] OP_WRSR  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_RDSR  = 8'h05;

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_PAGE = 2'b10;
    localparam logic [1:0] MODE_SEQ  = 2'b01;

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, DATA_RD, DATA_WR, SR_RD, SR_WR, IGNORE
    } state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// rtl/spi_edge_sync.sv - pad synchroniser with rise/fall pulses on the synchronised level
module spi_edge_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstb,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= (chain << 1) | STAGES'(d);
            prev  <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/spi_sram_slave.sv
// rtl/spi_sram_slave.sv - SPI mode-0 serial SRAM slave; SPI_SRAM_HOLD_EN adds the holdb pause input
module spi_sram_slave
    import spi_sram_pkg::*;
#(
    parameter int ADDR_BITS   = 16,
    parameter int MEM_AW      = 13,
    parameter int PAGE_BYTES  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstb,
    input  logic csb,
    input  logic sck,
    input  logic si,
`ifdef SPI_SRAM_HOLD_EN
    input  logic holdb,
`endif
    output logic so,
    output logic so_oe
);

    localparam int CW = $clog2(ADDR_BITS > 8 ? ADDR_BITS : 8);
    localparam logic [MEM_AW-1:0] PAGE_MASK = MEM_AW'(PAGE_BYTES - 1);
`ifdef SPI_SRAM_HOLD_EN
    localparam logic [7:0] SR_WMASK = 8'hC1;
`else
    localparam logic [7:0] SR_WMASK = 8'hC0;
`endif

    logic csb_q, csb_rise, csb_fall;
    logic sck_q, sck_rise, sck_fall;
    logic si_q, si_rise, si_fall;

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csb (
        .clk(clk), .rstb(rstb), .d(csb), .q(csb_q), .rise(csb_rise), .fall(csb_fall));
    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk(clk), .rstb(rstb), .d(sck), .q(sck_q), .rise(sck_rise), .fall(sck_fall));
    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_si (
        .clk(clk), .rstb(rstb), .d(si), .q(si_q), .rise(si_rise), .fall(si_fall));

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [6:0]        shreg;
    logic [MEM_AW-1:0] addr;
    logic [7:0]        tx;
    logic [7:0]        status;
    logic              is_read;
    logic              hold;
    logic [7:0]        mem [0:2**MEM_AW-1];

`ifdef SPI_SRAM_HOLD_EN
    logic holdb_q, holdb_rise, holdb_fall;
    logic unused_ok;

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_holdb (
        .clk(clk), .rstb(rstb), .d(holdb), .q(holdb_q), .rise(holdb_rise), .fall(holdb_fall));

    // Hold only engages between sck pulses and drops as soon as holdb returns high.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)
            hold <= 1'b0;
        else if (csb_q || holdb_q || status[0])
            hold <= 1'b0;
        else if (!sck_q)
            hold <= 1'b1;
    end

    assign unused_ok = &{1'b0, csb_rise, csb_fall, si_rise, si_fall, holdb_rise, holdb_fall};
`else
    logic unused_ok;

    assign hold      = 1'b0;
    assign unused_ok = &{1'b0, csb_rise, csb_fall, si_rise, si_fall, sck_q};
`endif

    logic              rise_ok, fall_ok, byte_end, byte_mode, mem_we;
    logic [7:0]        rx_byte;
    logic [MEM_AW-1:0] addr_shift, addr_next;

    assign rise_ok    = sck_rise && !hold;
    assign fall_ok    = sck_fall && !hold;
    assign byte_end   = (cnt[2:0] == 3'd7);
    assign rx_byte    = {shreg, si_q};
    assign addr_shift = {addr[MEM_AW-2:0], si_q};
    assign byte_mode  = (status[7:6] == MODE_BYTE) || (status[7:6] == 2'b11);
    assign mem_we     = !csb_q && (state == DATA_WR) && rise_ok && byte_end;

    always_comb begin
        addr_next = addr;
        if (status[7:6] == MODE_PAGE)
            addr_next = (addr & ~PAGE_MASK) | ((addr + MEM_AW'(1)) & PAGE_MASK);
        else if (status[7:6] == MODE_SEQ)
            addr_next = addr + MEM_AW'(1);
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[addr] <= rx_byte;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            addr    <= '0;
            tx      <= '0;
            status  <= '0;
            is_read <= 1'b0;
            so      <= 1'b0;
            so_oe   <= 1'b0;
        end else if (csb_q) begin
            state <= IDLE;
            cnt   <= '0;
            so    <= 1'b0;
            so_oe <= 1'b0;
        end else begin
            so_oe <= (state == DATA_RD || state == SR_RD) && !hold;
            case (state)
                IDLE: begin
                    state <= CMD;
                    cnt   <= '0;
                end
                CMD: if (rise_ok) begin
                    shreg <= {shreg[5:0], si_q};
                    cnt   <= byte_end ? '0 : cnt + CW'(1);
                    if (byte_end) begin
                        is_read <= (rx_byte == OP_READ);
                        case (rx_byte)
                            OP_READ, OP_WRITE: state <= ADDR;
                            OP_RDSR: begin
                                state <= SR_RD;
                                tx    <= status;
                            end
                            OP_WRSR: state <= SR_WR;
                            default: state <= IGNORE;
                        endcase
                    end
                end
                ADDR: if (rise_ok) begin
                    addr <= addr_shift;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(ADDR_BITS - 1)) begin
                        cnt <= '0;
                        if (is_read) begin
                            tx    <= mem[addr_shift];
                            state <= DATA_RD;
                        end else begin
                            state <= DATA_WR;
                        end
                    end
                end
                DATA_WR: if (rise_ok) begin
                    shreg <= {shreg[5:0], si_q};
                    cnt   <= byte_end ? '0 : cnt + CW'(1);
                    if (byte_end) begin
                        if (byte_mode) state <= IGNORE;
                        else           addr  <= addr_next;
                    end
                end
                DATA_RD, SR_RD: begin
                    if (fall_ok) begin
                        so <= tx[7];
                        tx <= {tx[6:0], 1'b0};
                    end
                    if (rise_ok) begin
                        cnt <= byte_end ? '0 : cnt + CW'(1);
                        // Next byte is fetched on the 8th rise so its MSB is ready for the coming fall.
                        if (byte_end) begin
                            if (state == SR_RD) begin
                                tx <= status;
                            end else if (byte_mode) begin
                                state <= IGNORE;
                            end else begin
                                addr <= addr_next;
                                tx   <= mem[addr_next];
                            end
                        end
                    end
                end
                SR_WR: if (rise_ok) begin
                    shreg <= {shreg[5:0], si_q};
                    cnt   <= byte_end ? '0 : cnt + CW'(1);
                    if (byte_end) begin
                        status <= rx_byte & SR_WMASK;
                        state  <= IGNORE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_sram_slave.sv
// tb/tb_spi_sram_slave.sv - scoreboard bench for spi_sram_slave (hold checks under SPI_SRAM_HOLD_EN)
module tb_spi_sram_slave;

    localparam int HALF = 5;

    logic clk  = 1'b0;
    logic rstb = 1'b0;
    logic csb  = 1'b1;
    logic sck  = 1'b0;
    logic si   = 1'b0;
`ifdef SPI_SRAM_HOLD_EN
    logic holdb = 1'b1;
`endif
    logic so, so_oe;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    spi_sram_slave dut (
        .clk(clk),
        .rstb(rstb),
        .csb(csb),
        .sck(sck),
        .si(si),
`ifdef SPI_SRAM_HOLD_EN
        .holdb(holdb),
`endif
        .so(so),
        .so_oe(so_oe)
    );

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic spi_bit(input logic b);
        si = b;
        wait_clk(HALF);
        sck = 1'b1;
        wait_clk(HALF);
        sck = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    endtask

    task automatic cs_start();
        csb = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_end();
        wait_clk(HALF);
        csb = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic cmd_addr(input logic [7:0] op, input logic [15:0] a);
        send_byte(op);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
    endtask

    task automatic wr1(input logic [15:0] a, input logic [7:0] d);
        cs_start();
        cmd_addr(8'h02, a);
        send_byte(d);
        cs_end();
    endtask

    task automatic rd1(input logic [15:0] a, input logic [7:0] e);
        exp_q.push_back(e);
        cs_start();
        cmd_addr(8'h03, a);
        send_byte(8'h00);
        cs_end();
    endtask

    task automatic wrsr(input logic [7:0] v);
        cs_start();
        send_byte(8'h01);
        send_byte(v);
        cs_end();
    endtask

    task automatic rdsr(input logic [7:0] e, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(e);
        cs_start();
        send_byte(8'h05);
        for (int i = 0; i < n; i++) send_byte(8'h00);
        cs_end();
    endtask

    task automatic pulse_reset();
        rstb = 1'b0;
        csb  = 1'b1;
        sck  = 1'b0;
        wait_clk(1);
        check("so_oe_in_reset", {7'd0, so_oe}, 8'h00);
        check("so_in_reset", {7'd0, so}, 8'h00);
        wait_clk(3);
        rstb = 1'b1;
        wait_clk(4);
    endtask

    // Monitor: assembles bytes from so while so_oe is high and scores them against the queue.
    logic [7:0] mbyte;
    int         mbits;
    initial begin
        mbyte = '0;
        mbits = 0;
        forever begin
            @(posedge sck or posedge csb);
            if (csb) begin
                mbits = 0;
            end else if (so_oe) begin
                mbyte = {mbyte[6:0], so};
                mbits++;
                if (mbits == 8) begin
                    mbits = 0;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL so_byte: got %h expected nothing queued", mbyte);
                    end else begin
                        check("so_byte", mbyte, exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wait_clk(3);
        check("reset_so", {7'd0, so}, 8'h00);
        check("reset_so_oe", {7'd0, so_oe}, 8'h00);
        rstb = 1'b1;
        wait_clk(4);
        rdsr(8'h00, 1);

        wr1(16'h0003, 8'h13);
        wr1(16'h0003, 8'h23);
        rd1(16'h0003, 8'h23);
        wr1(16'h1005, 8'h9A);
        rd1(16'h1005, 8'h9A);

        wr1(16'h0002, 8'h12);
        cs_start();
        cmd_addr(8'h02, 16'h0002);
        for (int i = 0; i < 7; i++) spi_bit(1'b1);
        cs_end();
        rd1(16'h0002, 8'h12);
        wr1(16'h0002, 8'h77);
        rd1(16'h0002, 8'h77);

        wr1(16'h4001, 8'h34);
        rd1(16'h0001, 8'h34);
        rd1(16'h8001, 8'h34);

        wrsr(8'h40);
        wr1(16'h0020, 8'h5F);
        cs_start();
        cmd_addr(8'h02, 16'h1FFE);
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
        cs_end();
        exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
        exp_q.push_back(8'hA3); exp_q.push_back(8'hA4);
        cs_start();
        cmd_addr(8'h03, 16'h1FFE);
        repeat (4) send_byte(8'h00);
        cs_end();

        wrsr(8'h80);
        cs_start();
        cmd_addr(8'h02, 16'h001F);
        send_byte(8'hB1); send_byte(8'hB2); send_byte(8'hB3);
        cs_end();
        rdsr(8'h80, 2);
        exp_q.push_back(8'hB1); exp_q.push_back(8'hB2); exp_q.push_back(8'hB3);
        cs_start();
        cmd_addr(8'h03, 16'h001F);
        repeat (3) send_byte(8'h00);
        cs_end();
        rd1(16'h0020, 8'h5F);

`ifdef SPI_SRAM_HOLD_EN
        wrsr(8'hFF);
        rdsr(8'hC1, 1);
`else
        wrsr(8'hFF);
        rdsr(8'hC0, 1);
`endif
        wrsr(8'h00);
        rdsr(8'h00, 1);

        wr1(16'h0011, 8'h5A);
        cs_start();
        cmd_addr(8'h02, 16'h0010);
        send_byte(8'hC1);
        for (int i = 0; i < 4; i++) spi_bit(1'b0);
        check("so_oe_byte_mode_wr", {7'd0, so_oe}, 8'h00);
        for (int i = 0; i < 4; i++) spi_bit(1'b1);
        cs_end();
        exp_q.push_back(8'hC1);
        cs_start();
        cmd_addr(8'h03, 16'h0010);
        send_byte(8'h00);
        for (int i = 0; i < 4; i++) spi_bit(1'b0);
        check("so_oe_byte_mode_rd", {7'd0, so_oe}, 8'h00);
        for (int i = 0; i < 4; i++) spi_bit(1'b0);
        cs_end();
        rd1(16'h0011, 8'h5A);

        wrsr(8'h40);
        wr1(16'h0020, 8'h66);
        cs_start();
        cmd_addr(8'h03, 16'h0020);
        for (int i = 0; i < 3; i++) spi_bit(1'b0);
        check("so_oe_mid_read", {7'd0, so_oe}, 8'h01);
        pulse_reset();
        rdsr(8'h00, 1);
        cs_start();
        send_byte(8'h02);
        send_byte(8'h00);
        for (int i = 0; i < 4; i++) spi_bit(1'b0);
        pulse_reset();
        rd1(16'h0020, 8'h66);
        cs_start();
        cmd_addr(8'h02, 16'h0020);
        for (int i = 0; i < 7; i++) spi_bit(1'b1);
        pulse_reset();
        rd1(16'h0020, 8'h66);

`ifdef SPI_SRAM_HOLD_EN
        exp_q.push_back(8'hC1);
        cs_start();
        cmd_addr(8'h03, 16'h0010);
        for (int i = 0; i < 3; i++) spi_bit(1'b0);
        holdb = 1'b0;
        wait_clk(2 * HALF);
        check("so_oe_in_hold", {7'd0, so_oe}, 8'h00);
        for (int i = 0; i < 3; i++) spi_bit(1'b0);
        holdb = 1'b1;
        wait_clk(2 * HALF);
        for (int i = 0; i < 5; i++) spi_bit(1'b0);
        cs_end();
`endif

        wait_clk(4);
        check("scoreboard_drained", 8'(exp_q.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
